dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit that sits directly upstream of the banked 8K-word data memory. It accepts byte, halfword and word load/store requests from the core on a valid/ready handshake and converts them into the memory's word-only `mem_addr`/`rw`/`data_in` interface. Sub-word stores are done as read-modify-write. Load data is aligned and extended, and misaligned or out-of-range requests are rejected without touching memory.

## Interface
Parameters:
- `READ_LAT`, 2: cycles from the first cycle `mem_addr` is driven (with `mem_rw`=0) to the cycle `mem_rdata` is valid; legal range 1–7.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle, request accepted this edge if `req_valid`
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  load result (0 for stores and errors)
- `resp_err`  out  1  valid with `resp_valid`; request rejected
- `mem_addr`  out  13  word address to memory (`req_addr[14:2]`)
- `mem_rw`  out  1  1 = write, 0 = read
- `mem_wdata`  out  32  word write data
- `mem_rdata`  in  32  word read data from memory

## Operation
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by `req_addr[1:0]`.
- Error checks are applied at accept:
  - `req_addr[31:15]` ≠ 0.
  - `req_size` = 3.
  - Halfword with `req_addr[0]`=1.
  - Word with `req_addr[1:0]` ≠ 0.
- On error the FSM goes IDLE→RESP with `resp_err`=1. No memory cycle is issued and `mem_rw` stays 0.
- FSM states are IDLE, RD, WR, RESP. All request fields are registered at accept.
  - IDLE: `req_ready`=1. On accept:
    - error → RESP
    - word store → WR
    - load or sub-word store → RD
  - RD: `mem_rw`=0 and `mem_addr` is held. A 3-bit counter is loaded with `READ_LAT` on entry and decrements each cycle. In the cycle it reads 1, `mem_rdata` is captured at the edge, and the FSM moves to WR for sub-word stores or RESP for loads.
  - WR: one cycle, `mem_rw`=1 and `mem_addr` held.
    - Word store: `mem_wdata` = `req_wdata`.
    - Byte store: the captured word with lane `addr[1:0]` replaced by `req_wdata[7:0]`.
    - Halfword store: the captured word with half `addr[1]` replaced by `req_wdata[15:0]`. Other lanes are unchanged.
    - Next state: RESP.
  - RESP: one cycle, `resp_valid`=1, then IDLE.
    - Loads: `resp_rdata` = selected lane/half/word, extended per `req_signed`.
- `req_ready` = (state == IDLE). There is at most one outstanding request and no pipelining.
- `mem_addr`, `mem_rw` and `mem_wdata` come from registers. `mem_addr` and `mem_wdata` hold their last values in IDLE/RESP. `mem_rw` is 1 only in WR.
- Bank crossings need no special handling: `mem_addr[12:10]` is bank select and is driven as-is.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_addr`=0, `mem_rw`=0, `mem_wdata`=0, counter 0.
- Latency is measured from the accept edge E to the edge at which `resp_valid` is sampled high:
  - Error: E+1.
  - Word store: E+2.
  - Load: E+`READ_LAT`+1.
  - Sub-word store: E+`READ_LAT`+2.
- The next request can be accepted at the edge that ends RESP-idle, i.e. the cycle after the `resp_valid` pulse. Back-to-back store→load to the same address returns the new data.
- Reset asserted mid-operation:
  - `mem_rw` drops to 0 immediately (asynchronous).
  - The request is discarded and no `resp_valid` is issued.
  - A partial RMW must not write memory.
- Request inputs are ignored while `req_ready`=0.

## Test plan
- Word store 0x11223344 to 0x0000_1000 then load word from 0x0000_1000 → `mem_addr`=0x400, `resp_rdata`=0x11223344 at E+`READ_LAT`+1, `resp_err`=0.
- Byte store 0xAB to 0x0000_1003 over 0x11223344 → WR cycle `mem_wdata`=0xAB223344. Signed byte load from 0x1003 → 0xFFFFFFAB. Unsigned byte load → 0x000000AB.
- Halfword store 0x8001 to 0x0000_1002, then:
  - signed half load → 0xFFFF8001
  - word load → 0x80013344
- Misaligned half load at 0x0000_0003, word store at 0x0000_0002, and address 0x0000_8000 → each gives `resp_err`=1 at E+1, `mem_rw` never 1, `resp_rdata`=0.
- Bank boundary: word stores to 0x0000_0FFC (`mem_addr`=0x3FF) and 0x0000_1000 (0x400) with distinct data → both read back intact.
- Assert `reset` during RD of a byte store → `mem_rw` stays 0, no `resp_valid`. After release `req_ready`=1 and a word load returns the original value.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte/half/word load-store unit in front of a word-only data memory;
// sub-word stores are read-modify-write, loads are lane-aligned and extended.
module dmem_lsu #(
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [12:0] mem_addr,
  output logic        mem_rw,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d, sgn_q, sgn_d, err_q, err_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [12:0] mem_addr_q, mem_addr_d;
  logic        mem_rw_q, mem_rw_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        req_err;
  logic [4:0]  sh;
  logic [31:0] mask, merged, lane, ext;
  assign req_err = (|req_addr[31:15]) || (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && |req_addr[1:0]);
  assign sh     = {off_q, 3'b000};
  assign mask   = (size_q == 2'd0) ? 32'h0000_00ff : 32'h0000_ffff;
  assign merged = (mem_rdata & ~(mask << sh)) | ((wdata_q & mask) << sh);
  assign lane   = rdata_q >> sh;
  assign ext    = (size_q == 2'd0) ? {{24{sgn_q & lane[7]}}, lane[7:0]} :
                  (size_q == 2'd1) ? {{16{sgn_q & lane[15]}}, lane[15:0]} : rdata_q;
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !err_q && !we_q) ? ext : 32'd0;
  assign mem_addr   = mem_addr_q;
  assign mem_rw     = mem_rw_q;
  assign mem_wdata  = mem_wdata_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    sgn_d       = sgn_q;
    err_d       = err_q;
    size_d      = size_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_rw_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        sgn_d   = req_signed;
        size_d  = req_size;
        off_d   = req_addr[1:0];
        wdata_d = req_wdata;
        err_d   = req_err;
        if (req_err) state_d = RESP;
        else begin
          mem_addr_d = req_addr[14:2];
          if (req_we && req_size == 2'd2) begin
            state_d     = WR;
            mem_rw_d    = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = RD;
            cnt_d   = 3'(READ_LAT);
          end
        end
      end
      RD: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = mem_rdata;
          state_d = we_q ? WR : RESP;
          // the merge uses the live read word so the write issues right after the read
          mem_rw_d    = we_q;
          mem_wdata_d = we_q ? merged : mem_wdata_q;
        end
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      we_q        <= 1'b0;
      sgn_q       <= 1'b0;
      err_q       <= 1'b0;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      mem_addr_q  <= 13'd0;
      mem_rw_q    <= 1'b0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      sgn_q       <= sgn_d;
      err_q       <= err_d;
      size_q      <= size_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_rw_q    <= mem_rw_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: random and directed requests checked every cycle against a
// request-level model of memory contents, latency and write traffic.
module tb_dmem_lsu;
  localparam int RL = 3;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err, mem_rw;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [12:0] mem_addr;
  int checks = 0, errors = 0;

  dmem_lsu #(.READ_LAT(RL)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] h(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic bad(input logic [31:0] a, input logic [1:0] s);
    return (a >= 32'h8000) || (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] szmask(input logic [1:0] s);
    return (s == 2'd0) ? 32'hFF : (s == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] s, input logic sg);
    logic [31:0] v, m;
    m = szmask(s);
    v = (w >> (8 * off)) & m;
    if (sg && s == 2'd0 && v >= 32'h80) v = v | ~m;
    if (sg && s == 2'd1 && v >= 32'h8000) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] s, input logic [31:0] d);
    logic [31:0] m;
    m = szmask(s) << (8 * off);
    return (w & ~m) | ((d << (8 * off)) & m);
  endfunction

  function automatic int lat_of(input logic e, input logic we, input logic [1:0] s);
    return e ? 1 : (we && s == 2'd2) ? 2 : we ? RL + 2 : RL + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // memory with RL-cycle read latency
  logic [31:0] tb_mem [8192];
  logic [31:0] rp [RL-1];
  assign mem_rdata = rp[RL-2];
  initial begin
    for (int i = 0; i < 8192; i++) tb_mem[i] = h(i);
    for (int i = 0; i < RL - 1; i++) rp[i] = 32'd0;
    forever begin
      @(posedge clk);
      if (mem_rw) tb_mem[mem_addr] <= mem_wdata;
      rp[0] <= tb_mem[mem_addr];
      for (int i = 1; i < RL - 1; i++) rp[i] <= rp[i-1];
    end
  end

  // reference model: one outstanding request, expectations fixed at accept
  logic [31:0] ref_mem [8192];
  int          cyc, due;
  logic        busy, m_err, m_we;
  logic [12:0] m_wi;
  logic [31:0] m_wword, m_rdata;
  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = h(i);
    cyc = 0; due = 0; busy = 1'b0; m_err = 1'b0; m_we = 1'b0;
    m_wi = 13'd0; m_wword = 32'd0; m_rdata = 32'd0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) busy <= 1'b0;
      else begin
        cyc <= cyc + 1;
        if (busy && cyc == due - 1 && m_we && !m_err) ref_mem[m_wi] <= m_wword;
        if (busy && cyc == due) busy <= 1'b0;
        if (req_valid && req_ready) begin
          busy    <= 1'b1;
          m_err   <= bad(req_addr, req_size);
          m_we    <= req_we;
          m_wi    <= req_addr[14:2];
          due     <= cyc + lat_of(bad(req_addr, req_size), req_we, req_size);
          m_wword <= store_val(ref_mem[req_addr[14:2]], req_addr[1:0], req_size, req_wdata);
          m_rdata <= (req_we || bad(req_addr, req_size)) ? 32'd0 :
                     load_val(ref_mem[req_addr[14:2]], req_addr[1:0], req_size, req_signed);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_rw", 32'(mem_rw), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
    end else begin
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("resp_valid", 32'(resp_valid), 32'(busy && cyc == due));
      if (busy && cyc == due) begin
        chk("resp_err", 32'(resp_err), 32'(m_err));
        chk("resp_rdata", resp_rdata, m_rdata);
      end
      chk("mem_rw", 32'(mem_rw), 32'(busy && m_we && !m_err && cyc == due - 1));
      if (busy && m_we && !m_err && cyc == due - 1) chk("mem_wdata", mem_wdata, m_wword);
      if (busy && !m_err) chk("mem_addr", 32'(mem_addr), 32'(m_wi));
    end
  end

  task automatic junk();
    req_valid  = 1'($urandom);
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat,
                        output logic [12:0] ma, output logic saw_rw, output logic [31:0] wword);
    int n;
    rd = 32'd0; e = 1'b0; lat = 0; ma = 13'd0; saw_rw = 1'b0; wword = 32'd0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (mem_rw) begin saw_rw = 1'b1; wword = mem_wdata; end
      if (resp_valid || n >= 20) break;
      junk();
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: resp_valid stayed %b after %0d cycles, required 1", resp_valid, n);
    end
    rd = resp_rdata; e = resp_err; lat = n; ma = mem_addr;
    req_valid = 1'b0;
  endtask

  logic [31:0] rd, wword, a, d;
  logic        e, saw, we, sg;
  logic [1:0]  sz;
  logic [12:0] ma;
  int          lat;

  initial begin
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    // word store then word load
    do_req(1, 2, 0, 32'h1000, 32'h11223344, rd, e, lat, ma, saw, wword);
    chk("ws_lat", 32'(lat), 32'd2);
    chk("ws_wdata", wword, 32'h11223344);
    do_req(0, 2, 0, 32'h1000, 0, rd, e, lat, ma, saw, wword);
    chk("lw_data", rd, 32'h11223344);
    chk("lw_addr", 32'(ma), 32'h400);
    chk("lw_lat", 32'(lat), 32'(RL + 1));
    chk("lw_err", 32'(e), 32'd0);
    // byte store and byte loads
    do_req(1, 0, 0, 32'h1003, 32'h000000AB, rd, e, lat, ma, saw, wword);
    chk("sb_wdata", wword, 32'hAB223344);
    chk("sb_lat", 32'(lat), 32'(RL + 2));
    do_req(0, 0, 1, 32'h1003, 0, rd, e, lat, ma, saw, wword);
    chk("lb_signed", rd, 32'hFFFFFFAB);
    do_req(0, 0, 0, 32'h1003, 0, rd, e, lat, ma, saw, wword);
    chk("lb_unsigned", rd, 32'h000000AB);
    // halfword store and loads
    do_req(1, 1, 0, 32'h1002, 32'h00008001, rd, e, lat, ma, saw, wword);
    do_req(0, 1, 1, 32'h1002, 0, rd, e, lat, ma, saw, wword);
    chk("lh_signed", rd, 32'hFFFF8001);
    do_req(0, 2, 0, 32'h1000, 0, rd, e, lat, ma, saw, wword);
    chk("lw_after_sh", rd, 32'h80013344);
    // rejected requests
    do_req(0, 1, 0, 32'h0003, 0, rd, e, lat, ma, saw, wword);
    chk("mis_half_err", 32'(e), 32'd1);
    chk("mis_half_lat", 32'(lat), 32'd1);
    chk("mis_half_data", rd, 32'd0);
    do_req(1, 2, 0, 32'h0002, 32'hDEADBEEF, rd, e, lat, ma, saw, wword);
    chk("mis_word_err", 32'(e), 32'd1);
    chk("mis_word_rw", 32'(saw), 32'd0);
    do_req(0, 2, 0, 32'h8000, 0, rd, e, lat, ma, saw, wword);
    chk("range_err", 32'(e), 32'd1);
    chk("range_data", rd, 32'd0);
    // bank boundary
    do_req(1, 2, 0, 32'h0FFC, 32'hCAFEF00D, rd, e, lat, ma, saw, wword);
    chk("bank_lo_addr", 32'(ma), 32'h3FF);
    do_req(1, 2, 0, 32'h1000, 32'h0BADBEEF, rd, e, lat, ma, saw, wword);
    do_req(0, 2, 0, 32'h0FFC, 0, rd, e, lat, ma, saw, wword);
    chk("bank_lo_data", rd, 32'hCAFEF00D);
    do_req(0, 2, 0, 32'h1000, 0, rd, e, lat, ma, saw, wword);
    chk("bank_hi_data", rd, 32'h0BADBEEF);
    // reset during the read phase of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h2001; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk("mid_rst_rw", 32'(mem_rw), 32'd0);
    chk("mid_rst_resp", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    do_req(0, 2, 0, 32'h2000, 0, rd, e, lat, ma, saw, wword);
    chk("post_rst_data", rd, h(32'h800));
    // random traffic near the bank boundary
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      sg = 1'($urandom);
      sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = {17'd0, 13'($urandom_range(32'h3F8, 32'h407)), 2'd0};
      a  = a | (($urandom % 4 == 0) ? 32'($urandom % 4) : (sz == 2'd0) ? 32'($urandom % 4) :
                (sz == 2'd1) ? 32'(2 * ($urandom % 2)) : 32'd0);
      if ($urandom % 16 == 0) a = a | ($urandom << 15);
      d  = $urandom;
      do_req(we, sz, sg, a, d, rd, e, lat, ma, saw, wword);
      repeat ($urandom % 3) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
